ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Consumes the 9-bit frames and `rdy` strobe produced by the PS/2 controller and turns keyboard scan codes (set 2) into ASCII characters. Tracks make/break prefixes, Shift and Caps Lock, and queues printable characters in a small FIFO read by the downstream text/display logic. Sits directly after `PS2_Controller` and shares its clock, enable and reset.

## Interface
- `DEPTH`, 4: character FIFO depth (power of two, ≥2)
- `CLK`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `en`  in  1  block enable; low freezes all state (intake and reads)
- `Q`  in  9  frame from controller: `Q[7:0]` scan code, `Q[8]` odd-parity bit
- `rdy`  in  1  controller frame-ready level; a new frame is its 0→1 edge
- `char_rd`  in  1  pop request from consumer
- `char`  out  8  ASCII at FIFO head (0x00 when empty)
- `char_valid`  out  1  FIFO non-empty
- `full`  out  1  FIFO holds DEPTH entries
- `overflow`  out  1  sticky: a character was dropped because FIFO full
- `perr`  out  1  one-cycle pulse: parity error (only with macro)
- `shift_on`, `caps_on`  out  1 each  current modifier state

## Operation
- `rdy` registered into `rdy_q`; frame accepted at the clock edge where `en & rdy & ~rdy_q`. A level held high accepts once.
- FSM states: IDLE, BRK (after 0xF0), EXT (after 0xE0), EXT_BRK (0xE0 then 0xF0).
  - IDLE: 0xF0→BRK; 0xE0→EXT; other code = make, processed, stay IDLE.
  - BRK: any code = break, processed, →IDLE.
  - EXT: 0xF0→EXT_BRK; other code discarded →IDLE.
  - EXT_BRK: any code discarded →IDLE.
- Make 0x12 or 0x59 sets shift (per-key flag, `shift_on` = L|R); break clears that key's flag.
- Make 0x58 toggles `caps_on`; break ignored. Autorepeated makes toggle each time.
- Printable makes: letters a–z → lowercase unless `shift_on ^ caps_on`; digits/punctuation use `shift_on` only; 0x29→0x20, 0x5A→0x0D, 0x66→0x08, 0x0D→0x09. Unmapped codes and all breaks enqueue nothing.
- FIFO: write on accept of printable make; read when `char_rd & char_valid`. Read on empty ignored. Write while full with no read: dropped, `overflow` set. Simultaneous read+write when full: both occur, count unchanged.
- Reset: FSM IDLE, modifiers 0, FIFO empty, `rdy_q`=0; all outputs 0.

## Timing
- Accept edge N: FSM/modifiers update at N; enqueued char appears on `char`/`char_valid` after edge N (visible cycle N+1). Latency rdy rise → char_valid: 1 clock.
- Modifier on a frame affects only subsequent frames.
- `char` is head-of-FIFO combinationally from registered storage; advances the cycle after the pop edge.
- `perr` high for exactly the cycle after the offending accept edge.
- `en` low: no state changes including `rdy_q`; reset still applies regardless of `en`.
- Reset mid-prefix (e.g. in BRK) returns to IDLE; next code is a make.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: accepted frame with even parity over `Q[8:0]` is discarded (no FSM/modifier/FIFO change) and pulses `perr`.
- Not defined: `Q[8]` ignored, `perr` tied 0.

## Structure
- Package `ps2_pkg`: FSM state enum; constants `SC_BREAK`=0xF0, `SC_EXT`=0xE0, `SC_LSHIFT`=0x12, `SC_RSHIFT`=0x59, `SC_CAPS`=0x58; ASCII constants for CR/BS/TAB/SPACE.
- Sub-module `ps2_scan_lut`: combinational scan code + shift/caps → {printable, ascii[7:0]}. FIFO inline.

## Test plan
- Reset, then idle 10 cycles → all outputs 0, `char_valid`=0.
- Frame 0x1C → next cycle `char`=0x61, `char_valid`=1; `char_rd` one cycle → `char_valid`=0.
- 0x12,0x1C,0xF0,0x1C,0xF0,0x12,0x1C → FIFO holds 0x41, 0x61; `shift_on` 0 at end.
- 0x58,0xF0,0x58,0x1C then 0x12,0x1C → 0x41 then 0x61; 0x12,0x16 with caps → 0x21.
- DEPTH=4, frames 0x1C,0x32,0x21,0x23,0x24 no reads → `full`=1, `overflow`=1, reads yield 0x61,0x62,0x63,0x64; E0,0x5A and E0,F0,0x5A enqueue nothing.
- Frame 0x1C with even parity: macro on → `perr` pulse, no char; macro off → 0x61.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 key decoder.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } ps2_state_t;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_TAB   = 8'h09;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/ps2_scan_lut.sv
// Combinational scan code (set 2) to ASCII lookup with Shift / Caps Lock applied.
module ps2_scan_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic       printable,
  output logic [7:0] ascii
);

  logic [7:0] lo;
  logic [7:0] hi;
  logic       is_letter;

  always_comb begin
    printable = 1'b1;
    lo        = 8'h00;
    hi        = 8'h00;
    case (code)
      8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
      8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
      8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
      8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
      8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
      8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
      8'h35: lo = "y";  8'h1A: lo = "z";
      8'h45: begin lo = "0"; hi = ")"; end
      8'h16: begin lo = "1"; hi = "!"; end
      8'h1E: begin lo = "2"; hi = "@"; end
      8'h26: begin lo = "3"; hi = "#"; end
      8'h25: begin lo = "4"; hi = "$"; end
      8'h2E: begin lo = "5"; hi = "%"; end
      8'h36: begin lo = "6"; hi = "^"; end
      8'h3D: begin lo = "7"; hi = "&"; end
      8'h3E: begin lo = "8"; hi = "*"; end
      8'h46: begin lo = "9"; hi = "("; end
      8'h0E: begin lo = 8'h60; hi = 8'h7E; end
      8'h4E: begin lo = "-"; hi = "_"; end
      8'h55: begin lo = "="; hi = "+"; end
      8'h54: begin lo = "["; hi = "{"; end
      8'h5B: begin lo = "]"; hi = "}"; end
      8'h5D: begin lo = 8'h5C; hi = 8'h7C; end
      8'h4C: begin lo = ";"; hi = ":"; end
      8'h52: begin lo = 8'h27; hi = 8'h22; end
      8'h41: begin lo = ","; hi = "<"; end
      8'h49: begin lo = "."; hi = ">"; end
      8'h4A: begin lo = "/"; hi = "?"; end
      8'h29: begin lo = ASCII_SPACE; hi = ASCII_SPACE; end
      8'h5A: begin lo = ASCII_CR;    hi = ASCII_CR;    end
      8'h66: begin lo = ASCII_BS;    hi = ASCII_BS;    end
      8'h0D: begin lo = ASCII_TAB;   hi = ASCII_TAB;   end
      default: printable = 1'b0;
    endcase
  end

  // Letters carry only the lowercase glyph; uppercase is bit 5 cleared.
  assign is_letter = (lo >= "a") && (lo <= "z");

  always_comb begin
    ascii = 8'h00;
    if (printable) begin
      if (is_letter)
        ascii = (shift ^ caps) ? (lo & 8'hDF) : lo;
      else
        ascii = shift ? hi : lo;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: prefix FSM, Shift/Caps tracking, ASCII character FIFO.
// Define PS2_PARITY_CHECK_EN to discard frames with bad odd parity and pulse perr.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       en,
   input  logic [8:0] Q,
   input  logic       rdy,
   input  logic       char_rd,
   output logic [7:0] char,
   output logic       char_valid,
   output logic       full,
   output logic       overflow,
   output logic       perr,
   output logic       shift_on,
   output logic       caps_on,
   output logic [1:0] state_dbg
);

   // Consumer handshake: char is valid while char_valid is high; a pop happens on
   // any enabled edge with char_rd & char_valid; char_rd while empty is ignored.

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   ps2_state_t state, next_state;
   logic       rdy_q;
   logic       accept;
   logic       frame_bad;
   logic       frame_ok;
   logic       is_make;
   logic       is_break;
   logic       lshift, rshift;
   logic       printable;
   logic [7:0] lut_ascii;
   logic [7:0] code;

   logic [7:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          wr_req, do_wr, do_rd;

   assign code   = Q[7:0];
   assign accept = en & rdy & ~rdy_q;

`ifdef PS2_PARITY_CHECK_EN
   logic perr_q;
   // Valid frames have odd parity across all nine bits.
   assign frame_bad = ~(^Q);
   always_ff @(posedge CLK) begin
      if (reset) perr_q <= 1'b0;
      else       perr_q <= accept & frame_bad;
   end
   assign perr = perr_q;
`else
   logic unused_parity;
   assign unused_parity = Q[8];
   assign frame_bad     = 1'b0;
   assign perr          = 1'b0;
`endif

   assign frame_ok = accept & ~frame_bad;

   always_ff @(posedge CLK) begin
      if (reset)   rdy_q <= 1'b0;
      else if (en) rdy_q <= rdy;
   end

   always_ff @(posedge CLK) begin
      if (reset)         state <= ST_IDLE;
      else if (frame_ok) state <= next_state;
   end

   always_comb begin
      next_state = state;
      is_make    = 1'b0;
      is_break   = 1'b0;
      if (frame_ok) begin
         case (state)
            ST_IDLE: begin
               if (code == SC_BREAK)    next_state = ST_BRK;
               else if (code == SC_EXT) next_state = ST_EXT;
               else                     is_make    = 1'b1;
            end
            ST_BRK: begin
               is_break   = 1'b1;
               next_state = ST_IDLE;
            end
            ST_EXT: begin
               if (code == SC_BREAK) next_state = ST_EXT_BRK;
               else                  next_state = ST_IDLE;
            end
            ST_EXT_BRK: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
         endcase
      end
   end

   assign state_dbg = state;

   always_ff @(posedge CLK) begin
      if (reset) begin
         lshift  <= 1'b0;
         rshift  <= 1'b0;
         caps_on <= 1'b0;
      end else begin
         if (is_make && code == SC_LSHIFT)  lshift  <= 1'b1;
         if (is_make && code == SC_RSHIFT)  rshift  <= 1'b1;
         if (is_break && code == SC_LSHIFT) lshift  <= 1'b0;
         if (is_break && code == SC_RSHIFT) rshift  <= 1'b0;
         if (is_make && code == SC_CAPS)    caps_on <= ~caps_on;
      end
   end

   assign shift_on = lshift | rshift;

   // Lookup uses the modifiers as they stood before this frame.
   ps2_scan_lut u_lut (
      .code      (code),
      .shift     (shift_on),
      .caps      (caps_on),
      .printable (printable),
      .ascii     (lut_ascii)
   );

   assign char_valid = (count != '0);
   assign full       = (count == FULL_CNT);
   assign wr_req     = is_make & printable;
   assign do_rd      = en & char_rd & char_valid;
   assign do_wr      = wr_req & (~full | do_rd);

   always_ff @(posedge CLK) begin
      if (do_wr) mem[wr_ptr] <= lut_ascii;
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_req & full & ~do_rd) overflow <= 1'b1;
      end
   end

   assign char = char_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed vector table, corner sequences, random vs. model.
module tb_ps2_key_decoder;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic [8:0] Q = '0;
  logic       rdy = 1'b0;
  logic       char_rd = 1'b0;
  logic [7:0] char;
  logic       char_valid, full, overflow, perr, shift_on, caps_on;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  ps2_key_decoder #(.DEPTH(4)) dut (
    .CLK(CLK), .reset(reset), .en(en), .Q(Q), .rdy(rdy), .char_rd(char_rd),
    .char(char), .char_valid(char_valid), .full(full), .overflow(overflow),
    .perr(perr), .shift_on(shift_on), .caps_on(caps_on), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  // ---------------- driver tasks (start and end on a falling edge) ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; rdy = 1'b0; char_rd = 1'b0; en = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] sc, input bit good = 1'b1);
    @(negedge CLK);
    Q   = {(good ? ~(^sc) : (^sc)), sc};
    rdy = 1'b1;
    @(negedge CLK);
    rdy = 1'b0;
  endtask

  task automatic pop();
    @(negedge CLK);
    char_rd = 1'b1;
    @(negedge CLK);
    char_rd = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    check({name, "_valid"}, char_valid, 1);
    check({name, "_char"}, char, exp);
    pop();
  endtask

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];
  bit m_brk, m_ext, m_ls, m_rs, m_caps, m_ovf;

  logic [7:0] letter_sc[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
    8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,
    8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] digit_sc[10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] punct_sc[11] = '{8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,8'h4A};
  logic [7:0] ctrl_sc[4]   = '{8'h29,8'h5A,8'h66,8'h0D};
  logic [7:0] ctrl_ch[4]   = '{8'h20,8'h0D,8'h08,8'h09};
  string digit_shift = ")!@#$%^&*(";
  logic [7:0] punct_lo[11] = '{8'h60,8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,8'h2F};
  logic [7:0] punct_hi[11] = '{8'h7E,8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,8'h3A,8'h22,8'h3C,8'h3E,8'h3F};

  function automatic void model_map(input logic [7:0] sc, input bit sh, input bit cp,
                                    output bit pr, output logic [7:0] a);
    pr = 1'b0; a = 8'h00;
    for (int i = 0; i < 26; i++)
      if (sc == letter_sc[i]) begin pr = 1; a = 8'(97 + i - ((sh ^ cp) ? 32 : 0)); end
    for (int i = 0; i < 10; i++)
      if (sc == digit_sc[i]) begin pr = 1; a = sh ? digit_shift[i] : 8'(48 + i); end
    for (int i = 0; i < 11; i++)
      if (sc == punct_sc[i]) begin pr = 1; a = sh ? punct_hi[i] : punct_lo[i]; end
    for (int i = 0; i < 4; i++)
      if (sc == ctrl_sc[i]) begin pr = 1; a = ctrl_ch[i]; end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    m_brk = 0; m_ext = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_ovf = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] sc);
    bit pr; logic [7:0] a;
    if (m_ext) begin
      if (!m_brk && sc == 8'hF0) m_brk = 1;
      else begin m_ext = 0; m_brk = 0; end
    end else if (m_brk) begin
      m_brk = 0;
      if (sc == 8'h12) m_ls = 0;
      if (sc == 8'h59) m_rs = 0;
    end else if (sc == 8'hF0) m_brk = 1;
    else if (sc == 8'hE0) m_ext = 1;
    else begin
      model_map(sc, m_ls | m_rs, m_caps, pr, a);
      if (pr) begin
        if (exp_q.size() < 4) exp_q.push_back(a);
        else m_ovf = 1;
      end
      if (sc == 8'h12) m_ls = 1;
      if (sc == 8'h59) m_rs = 1;
      if (sc == 8'h58) m_caps = ~m_caps;
    end
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] code;
    bit         shift;
    bit         valid;
    logic [7:0] ascii;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs = '{
      '{8'h1C, 0, 1, 8'h61}, '{8'h1A, 0, 1, 8'h7A}, '{8'h1C, 1, 1, 8'h41},
      '{8'h45, 0, 1, 8'h30}, '{8'h16, 1, 1, 8'h21}, '{8'h4E, 1, 1, 8'h5F},
      '{8'h52, 0, 1, 8'h27}, '{8'h29, 0, 1, 8'h20}, '{8'h5A, 0, 1, 8'h0D},
      '{8'h66, 0, 1, 8'h08}, '{8'h0D, 0, 1, 8'h09}, '{8'h76, 0, 0, 8'h00},
      '{8'h5D, 1, 1, 8'h7C}, '{8'h4A, 0, 1, 8'h2F}};

    // Reset and idle
    do_reset();
    repeat (10) @(negedge CLK);
    check("rst_char", char, 0);
    check("rst_valid", char_valid, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_perr", perr, 0);
    check("rst_shift", shift_on, 0);
    check("rst_caps", caps_on, 0);

    // Single frame latency and pop
    send(8'h1C);
    check("lat_valid", char_valid, 1);
    check("lat_char", char, 8'h61);
    pop();
    check("lat_popped", char_valid, 0);
    check("lat_char0", char, 0);

    // Vector table
    foreach (vecs[i]) begin
      if (vecs[i].shift) send(8'h12);
      send(vecs[i].code);
      check($sformatf("vec%0d_valid", i), char_valid, vecs[i].valid);
      check($sformatf("vec%0d_char", i), char, vecs[i].ascii);
      if (vecs[i].valid) pop();
      check($sformatf("vec%0d_empty", i), char_valid, 0);
      if (vecs[i].shift) begin send(8'hF0); send(8'h12); end
      check($sformatf("vec%0d_shift", i), shift_on, 0);
    end

    // Shift make/break sequence
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12); send(8'h1C);
    check("shseq_shift", shift_on, 0);
    pop_expect("shseq0", 8'h41);
    pop_expect("shseq1", 8'h61);
    check("shseq_empty", char_valid, 0);

    // Caps Lock toggling, break ignored, shift inverts letters only
    send(8'h58); send(8'hF0); send(8'h58);
    check("caps_on", caps_on, 1);
    send(8'h1C);
    pop_expect("caps_A", 8'h41);
    send(8'h59); send(8'h1C);
    pop_expect("caps_shift_a", 8'h61);
    send(8'h16);
    pop_expect("caps_shift_bang", 8'h21);
    send(8'hF0); send(8'h59);
    send(8'h58);
    check("caps_off", caps_on, 0);

    // Fill, overflow, simultaneous read+write while full
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    check("fill_full", full, 1);
    check("fill_noovf", overflow, 0);
    send(8'h24);
    check("ovf_set", overflow, 1);
    check("ovf_full", full, 1);
    @(negedge CLK);
    Q = {~(^8'h2B), 8'h2B}; rdy = 1'b1; char_rd = 1'b1;
    @(negedge CLK);
    rdy = 1'b0; char_rd = 1'b0;
    check("rw_full", full, 1);
    pop_expect("rw0", 8'h62);
    pop_expect("rw1", 8'h63);
    pop_expect("rw2", 8'h64);
    pop_expect("rw3", 8'h66);
    check("rw_empty", char_valid, 0);
    pop();
    check("pop_empty_ignored", char_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Extended codes discarded
    send(8'hE0); send(8'h5A);
    send(8'hE0); send(8'hF0); send(8'h5A);
    check("ext_none", char_valid, 0);
    send(8'h1C);
    pop_expect("ext_then_make", 8'h61);

    // rdy held high accepts once
    @(negedge CLK);
    Q = {~(^8'h1C), 8'h1C}; rdy = 1'b1;
    repeat (4) @(negedge CLK);
    rdy = 1'b0;
    @(negedge CLK);
    pop_expect("level_once", 8'h61);
    check("level_once_empty", char_valid, 0);

    // en low freezes intake (including rdy_q) and reads
    en = 1'b0;
    @(negedge CLK);
    Q = {~(^8'h32), 8'h32}; rdy = 1'b1;
    repeat (2) @(negedge CLK);
    check("en_frozen", char_valid, 0);
    en = 1'b1;
    @(negedge CLK);
    rdy = 1'b0;
    check("en_resume", char, 8'h62);
    en = 1'b0;
    pop();
    check("en_no_pop", char_valid, 1);
    en = 1'b1;
    pop();
    check("en_pop", char_valid, 0);

    // Reset mid-prefix
    send(8'hF0);
    do_reset();
    check("rst_ovf_clr", overflow, 0);
    send(8'h1C);
    pop_expect("rst_midbrk", 8'h61);

    // Bad parity frame
    send(8'h1C, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("par_perr", perr, 1);
    check("par_nochar", char_valid, 0);
    @(negedge CLK);
    check("par_perr_once", perr, 0);
`else
    check("par_perr", perr, 0);
    pop_expect("par_ignored", 8'h61);
`endif

    // Randomized frames vs. model
    do_reset();
    model_clear();
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [7:0] sc;
      r = $urandom_range(0, 11);
      case (r)
        0: sc = 8'hF0;
        1: sc = 8'hE0;
        2: sc = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        3: sc = 8'h58;
        4: sc = 8'($urandom_range(0, 255));
        5: sc = digit_sc[$urandom_range(0, 9)];
        6: sc = punct_sc[$urandom_range(0, 10)];
        7: sc = ctrl_sc[$urandom_range(0, 3)];
        default: sc = letter_sc[$urandom_range(0, 25)];
      endcase
      send(sc);
      model_frame(sc);
      check("rnd_valid", char_valid, exp_q.size() > 0);
      check("rnd_full", full, exp_q.size() == 4);
      check("rnd_ovf", overflow, m_ovf);
      check("rnd_shift", shift_on, m_ls | m_rs);
      check("rnd_caps", caps_on, m_caps);
      if (exp_q.size() > 0) check("rnd_char", char, exp_q[0]);
      if ($urandom_range(0, 2) == 0) begin
        pop();
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    while (exp_q.size() > 0) pop_expect("rnd_drain", exp_q.pop_front());
    check("rnd_empty", char_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
